// File: rtl/sram_arb2_if.sv
// sram_arb2_if
// Bundles the two client request/response channels and the SRAM controller
// command channel of the two-client arbiter.
//   slave  : arbiter side (takes client requests and controller status,
//            drives client status and the controller command)
//   master : environment side (clients plus controller)
// Client channel cN_*: req, rw, addr, wdata in; busy, done, rdata, drop out.
// Controller channel : mem, rw, addr, data_f2s out; ready, data_s2f_r in.
interface sram_arb2_if #(
  parameter int AW = 18,
  parameter int DW = 16
);
  logic          c0_req;
  logic          c0_rw;
  logic [AW-1:0] c0_addr;
  logic [DW-1:0] c0_wdata;
  logic          c0_busy;
  logic          c0_done;
  logic [DW-1:0] c0_rdata;
  logic          c0_drop;

  logic          c1_req;
  logic          c1_rw;
  logic [AW-1:0] c1_addr;
  logic [DW-1:0] c1_wdata;
  logic          c1_busy;
  logic          c1_done;
  logic [DW-1:0] c1_rdata;
  logic          c1_drop;

  logic          mem;
  logic          rw;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_f2s;
  logic          ready;
  logic [DW-1:0] data_s2f_r;

  modport slave (
    input  c0_req, c0_rw, c0_addr, c0_wdata,
    input  c1_req, c1_rw, c1_addr, c1_wdata,
    input  ready, data_s2f_r,
    output c0_busy, c0_done, c0_rdata, c0_drop,
    output c1_busy, c1_done, c1_rdata, c1_drop,
    output mem, rw, addr, data_f2s
  );

  modport master (
    output c0_req, c0_rw, c0_addr, c0_wdata,
    output c1_req, c1_rw, c1_addr, c1_wdata,
    output ready, data_s2f_r,
    input  c0_busy, c0_done, c0_rdata, c0_drop,
    input  c1_busy, c1_done, c1_rdata, c1_drop,
    input  mem, rw, addr, data_f2s
  );
endinterface

// File: rtl/sram_arb2.sv
// sram_arb2
// Shares one SRAM controller between two clients. Each client posts a
// one-cycle request into a one-entry buffer; buffered requests are issued to
// the controller round-robin, and each client gets a done pulse plus read
// data when its transaction finishes.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset, clears all state
//   bus   : sram_arb2_if.slave (client channels and controller command)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no transaction in flight; issue the winner when ready=1
// S_LAUNCH| controller leaving idle; ready is not trusted this cycle
// S_WAIT  | waiting for ready=1 to complete the owner's transaction
module sram_arb2 #(
  parameter int AW = 18,
  parameter int DW = 16
) (
  input  logic        clk,
  input  logic        reset,
  sram_arb2_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t        r_state;
  logic [1:0]    r_valid;
  logic [1:0]    r_buf_rw;
  logic [AW-1:0] r_buf_addr  [2];
  logic [DW-1:0] r_buf_wdata [2];
  logic [1:0]    r_done;
  logic [1:0]    r_drop;
  logic [DW-1:0] r_rdata     [2];
  logic          r_ptr;      // last client served
  logic          r_owner;    // client owning the in-flight transaction
  logic          r_own_rd;   // in-flight transaction is a read

  logic [1:0]    w_req;
  logic [1:0]    w_rw;
  logic [AW-1:0] w_addr  [2];
  logic [DW-1:0] w_wdata [2];
  logic [1:0]    w_busy;
  logic          w_issue;
  logic          w_gnt;

  assign w_req      = {bus.c1_req, bus.c0_req};
  assign w_rw       = {bus.c1_rw, bus.c0_rw};
  assign w_addr[0]  = bus.c0_addr;
  assign w_addr[1]  = bus.c1_addr;
  assign w_wdata[0] = bus.c0_wdata;
  assign w_wdata[1] = bus.c1_wdata;

  // A client stays busy until the cycle its done pulse is visible, so it
  // may post its next request in that same cycle.
  assign w_busy[0] = r_valid[0] | ((r_state != S_IDLE) && (r_owner == 1'b0));
  assign w_busy[1] = r_valid[1] | ((r_state != S_IDLE) && (r_owner == 1'b1));

  // Tie goes to the client not served last; otherwise the only valid one.
  assign w_gnt   = (&r_valid) ? ~r_ptr : r_valid[1];
  assign w_issue = (r_state == S_IDLE) && bus.ready && (|r_valid);

  // The command strobe must go out in the issue cycle itself, so the
  // controller command is decoded from the winner's buffer, not registered.
  always_comb begin
    bus.mem      = 1'b0;
    bus.rw       = 1'b1;
    bus.addr     = '0;
    bus.data_f2s = '0;
    if (w_issue) begin
      bus.mem      = 1'b1;
      bus.rw       = r_buf_rw[w_gnt];
      bus.addr     = r_buf_addr[w_gnt];
      bus.data_f2s = r_buf_wdata[w_gnt];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_valid  <= '0;
      r_buf_rw <= '0;
      r_done   <= '0;
      r_drop   <= '0;
      r_ptr    <= 1'b1;
      r_owner  <= 1'b0;
      r_own_rd <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_buf_addr[i]  <= '0;
        r_buf_wdata[i] <= '0;
        r_rdata[i]     <= '0;
      end
    end else begin
      r_done <= '0;

      for (int i = 0; i < 2; i++) begin
        if (w_req[i]) begin
          if (w_busy[i]) begin
            r_drop[i] <= 1'b1;
          end else begin
            r_valid[i]     <= 1'b1;
            r_buf_rw[i]    <= w_rw[i];
            r_buf_addr[i]  <= w_addr[i];
            r_buf_wdata[i] <= w_wdata[i];
          end
        end
      end

      // A load needs valid=0 and an issue clears a valid=1 entry, so the
      // two updates to r_valid never target the same client in one cycle.
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_valid[w_gnt] <= 1'b0;
            r_owner        <= w_gnt;
            r_own_rd       <= r_buf_rw[w_gnt];
            r_ptr          <= w_gnt;
            r_state        <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.ready) begin
            r_done[r_owner] <= 1'b1;
            if (r_own_rd) begin
              r_rdata[r_owner] <= bus.data_s2f_r;
            end
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.c0_busy  = w_busy[0];
  assign bus.c1_busy  = w_busy[1];
  assign bus.c0_done  = r_done[0];
  assign bus.c1_done  = r_done[1];
  assign bus.c0_rdata = r_rdata[0];
  assign bus.c1_rdata = r_rdata[1];
  assign bus.c0_drop  = r_drop[0];
  assign bus.c1_drop  = r_drop[1];

endmodule

// File: tb/tb_sram_arb2.sv
// tb_sram_arb2
// Directed bench for sram_arb2 with a behavioural 2-cycle SRAM controller
// (idle -> x1 -> x2 -> idle, optional extra stall in x2). Memory resets to
// word i = 0x1000 + i (low 8 address bits index the model).
module tb_sram_arb2;
  localparam int AW = 18;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  sram_arb2_if #(.AW(AW), .DW(DW)) bus ();

  sram_arb2 #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- controller model ----------------
  logic [15:0] arr [256];
  int          m_st;
  int          m_cnt;
  logic        m_rw;
  logic [7:0]  m_addr;
  int          stall_extra = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_st           <= 0;
      m_cnt          <= 0;
      m_rw           <= 1'b1;
      m_addr         <= '0;
      bus.ready      <= 1'b1;
      bus.data_s2f_r <= '0;
      for (int i = 0; i < 256; i++) arr[i] <= 16'(16'h1000 + i);
    end else begin
      case (m_st)
        0: if (bus.mem) begin
             m_rw   <= bus.rw;
             m_addr <= bus.addr[7:0];
             if (!bus.rw) arr[bus.addr[7:0]] <= bus.data_f2s;
             m_cnt     <= stall_extra;
             bus.ready <= 1'b0;
             m_st      <= 1;
           end
        1: m_st <= 2;
        default: begin
          if (m_cnt > 0) m_cnt <= m_cnt - 1;
          else begin
            m_st      <= 0;
            bus.ready <= 1'b1;
            if (m_rw) bus.data_s2f_r <= arr[m_addr];
          end
        end
      endcase
    end
  end

  // ---------------- monitor ----------------
  int          iss_cyc[$];
  logic [17:0] iss_addr[$];
  logic        iss_rw[$];
  logic [15:0] iss_dat[$];
  int          d0_cyc[$];
  logic [15:0] d0_dat[$];
  int          d1_cyc[$];
  logic [15:0] d1_dat[$];
  int          both_cnt = 0;

  always @(negedge clk) begin
    if (bus.mem === 1'b1) begin
      iss_cyc.push_back(cyc);
      iss_addr.push_back(bus.addr);
      iss_rw.push_back(bus.rw);
      iss_dat.push_back(bus.data_f2s);
    end
    if (bus.c0_done === 1'b1) begin
      d0_cyc.push_back(cyc);
      d0_dat.push_back(bus.c0_rdata);
    end
    if (bus.c1_done === 1'b1) begin
      d1_cyc.push_back(cyc);
      d1_dat.push_back(bus.c1_rdata);
    end
    if (bus.c0_done === 1'b1 && bus.c1_done === 1'b1) both_cnt <= both_cnt + 1;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.c0_req = 1'b0;
    bus.c1_req = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_mem"},   32'(bus.mem), 0);
    chk({p, "_rw"},    32'(bus.rw), 1);
    chk({p, "_addr"},  32'(bus.addr), 0);
    chk({p, "_wd"},    32'(bus.data_f2s), 0);
    chk({p, "_busy"},  32'({bus.c1_busy, bus.c0_busy}), 0);
    chk({p, "_done"},  32'({bus.c1_done, bus.c0_done}), 0);
    chk({p, "_rd0"},   32'(bus.c0_rdata), 0);
    chk({p, "_rd1"},   32'(bus.c1_rdata), 0);
    chk({p, "_drop"},  32'({bus.c1_drop, bus.c0_drop}), 0);
  endtask

  // Pulse one client's request for one cycle; t = cycle the req is high.
  task automatic creq(input int c, input logic rw, input logic [17:0] a,
                      input logic [15:0] d, output int t);
    if (c == 0) begin
      bus.c0_rw = rw; bus.c0_addr = a; bus.c0_wdata = d; bus.c0_req = 1'b1;
    end else begin
      bus.c1_rw = rw; bus.c1_addr = a; bus.c1_wdata = d; bus.c1_req = 1'b1;
    end
    t = cyc;
    step(1);
    bus.c0_req = 1'b0;
    bus.c1_req = 1'b0;
  endtask

  task automatic both_req(input logic [17:0] a0, input logic [17:0] a1, output int t);
    bus.c0_rw = 1'b1; bus.c0_addr = a0; bus.c0_wdata = '0; bus.c0_req = 1'b1;
    bus.c1_rw = 1'b1; bus.c1_addr = a1; bus.c1_wdata = '0; bus.c1_req = 1'b1;
    t = cyc;
    step(1);
    bus.c0_req = 1'b0;
    bus.c1_req = 1'b0;
  endtask

  initial begin
    int t, i0, j0, k0b;
    int n0, n1, k0, k1;
    bus.c0_req = 1'b0; bus.c0_rw = 1'b1; bus.c0_addr = '0; bus.c0_wdata = '0;
    bus.c1_req = 1'b0; bus.c1_rw = 1'b1; bus.c1_addr = '0; bus.c1_wdata = '0;

    // ---- 1: reset values, write then read back ----
    do_reset();
    @(negedge clk);
    chk_reset_vals("rst");
    step(1);
    i0 = iss_cyc.size(); j0 = d0_cyc.size();
    creq(0, 1'b0, 18'h00010, 16'hA5A5, t);
    @(negedge clk);
    chk("wr_busy", 32'(bus.c0_busy), 1);
    step(7);
    chk("wr_nissue", iss_cyc.size() - i0, 1);
    if (iss_cyc.size() > i0) begin
      chk("wr_iss_cyc", iss_cyc[i0], t + 1);
      chk("wr_iss_addr", 32'(iss_addr[i0]), 32'h10);
      chk("wr_iss_rw", 32'(iss_rw[i0]), 0);
      chk("wr_iss_dat", 32'(iss_dat[i0]), 32'hA5A5);
    end
    chk("wr_ndone", d0_cyc.size() - j0, 1);
    if (d0_cyc.size() > j0) chk("wr_done_cyc", d0_cyc[j0], t + 5);
    chk("wr_busy_end", 32'(bus.c0_busy), 0);

    i0 = iss_cyc.size(); j0 = d0_cyc.size();
    creq(0, 1'b1, 18'h00010, 16'h0000, t);
    step(7);
    chk("rd_nissue", iss_cyc.size() - i0, 1);
    if (iss_cyc.size() > i0) begin
      chk("rd_iss_cyc", iss_cyc[i0], t + 1);
      chk("rd_iss_rw", 32'(iss_rw[i0]), 1);
    end
    chk("rd_ndone", d0_cyc.size() - j0, 1);
    if (d0_cyc.size() > j0) begin
      chk("rd_done_cyc", d0_cyc[j0], t + 5);
      chk("rd_data", 32'(d0_dat[j0]), 32'hA5A5);
    end

    // ---- 2: simultaneous requests, c0 wins first tie ----
    do_reset();
    i0 = iss_cyc.size(); j0 = d0_cyc.size(); k0b = d1_cyc.size();
    both_req(18'h00001, 18'h00002, t);
    step(12);
    chk("tie_nissue", iss_cyc.size() - i0, 2);
    if (iss_cyc.size() > i0 + 1) begin
      chk("tie_iss0_cyc", iss_cyc[i0], t + 1);
      chk("tie_iss0_addr", 32'(iss_addr[i0]), 1);
      chk("tie_iss1_cyc", iss_cyc[i0+1], t + 5);
      chk("tie_iss1_addr", 32'(iss_addr[i0+1]), 2);
    end
    chk("tie_nd0", d0_cyc.size() - j0, 1);
    chk("tie_nd1", d1_cyc.size() - k0b, 1);
    if (d0_cyc.size() > j0 && d1_cyc.size() > k0b) begin
      chk("tie_d0_cyc", d0_cyc[j0], t + 5);
      chk("tie_d0_dat", 32'(d0_dat[j0]), 32'h1001);
      chk("tie_d1_cyc", d1_cyc[k0b], t + 9);
      chk("tie_d1_dat", 32'(d1_dat[k0b]), 32'h1002);
    end

    // ---- 3: streaming reads, strict alternation ----
    do_reset();
    i0 = iss_cyc.size();
    @(negedge clk);
    bus.c0_rw = 1'b1; bus.c0_addr = 18'h100; bus.c0_req = 1'b1;
    bus.c1_rw = 1'b1; bus.c1_addr = 18'h200; bus.c1_req = 1'b1;
    n0 = 1; n1 = 1; k0 = 0; k1 = 0;
    for (int k = 0; k < 150 && (k0 + k1) < 8; k++) begin
      @(negedge clk);
      bus.c0_req = 1'b0;
      bus.c1_req = 1'b0;
      if (bus.c0_done === 1'b1) begin
        k0++;
        if (n0 < 4) begin
          bus.c0_addr = 18'(18'h100 + n0); bus.c0_req = 1'b1; n0++;
        end
      end
      if (bus.c1_done === 1'b1) begin
        k1++;
        if (n1 < 4) begin
          bus.c1_addr = 18'(18'h200 + n1); bus.c1_req = 1'b1; n1++;
        end
      end
    end
    step(1);
    chk("rr_ndone0", k0, 4);
    chk("rr_ndone1", k1, 4);
    chk("rr_nissue", iss_cyc.size() - i0, 8);
    for (int m = 0; m < 8; m++) begin
      if (iss_cyc.size() > i0 + m) begin
        chk($sformatf("rr_addr%0d", m), 32'(iss_addr[i0+m]),
            ((m % 2) == 0) ? 32'h100 + 32'(m / 2) : 32'h200 + 32'(m / 2));
        if (m > 0) chk($sformatf("rr_gap%0d", m), iss_cyc[i0+m] - iss_cyc[i0+m-1], 4);
      end
    end
    chk("rr_drop", 32'({bus.c1_drop, bus.c0_drop}), 0);

    // ---- 4: request while busy is dropped ----
    do_reset();
    i0 = iss_cyc.size(); k0b = d1_cyc.size();
    creq(1, 1'b1, 18'h00003, 16'h0000, t);
    creq(1, 1'b0, 18'h0003F, 16'hDEAD, n0);
    @(negedge clk);
    chk("drop_set", 32'(bus.c1_drop), 1);
    chk("drop_c0", 32'(bus.c0_drop), 0);
    step(10);
    chk("drop_nissue", iss_cyc.size() - i0, 1);
    if (iss_cyc.size() > i0) chk("drop_iss_addr", 32'(iss_addr[i0]), 3);
    chk("drop_ndone", d1_cyc.size() - k0b, 1);
    if (d1_cyc.size() > k0b) begin
      chk("drop_done_cyc", d1_cyc[k0b], t + 5);
      chk("drop_rdata", 32'(d1_dat[k0b]), 32'h1003);
    end
    chk("drop_sticky", 32'(bus.c1_drop), 1);

    // ---- 5: controller stalls 10 extra cycles ----
    do_reset();
    stall_extra = 10;
    i0 = iss_cyc.size(); j0 = d0_cyc.size();
    creq(0, 1'b1, 18'h00020, 16'h0000, t);
    step(8);
    chk("stall_busy", 32'(bus.c0_busy), 1);
    chk("stall_nd_mid", d0_cyc.size() - j0, 0);
    step(12);
    stall_extra = 0;
    chk("stall_nissue", iss_cyc.size() - i0, 1);
    chk("stall_ndone", d0_cyc.size() - j0, 1);
    if (d0_cyc.size() > j0) begin
      chk("stall_done_cyc", d0_cyc[j0], t + 15);
      chk("stall_rdata", 32'(d0_dat[j0]), 32'h1020);
    end

    // ---- 6: reset during LAUNCH with c1 buffered ----
    do_reset();
    i0 = iss_cyc.size(); j0 = d0_cyc.size(); k0b = d1_cyc.size();
    both_req(18'h00001, 18'h00002, t);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("mid");
    step(10);
    chk("mid_nissue", iss_cyc.size() - i0, 1);
    chk("mid_nd0", d0_cyc.size() - j0, 0);
    chk("mid_nd1", d1_cyc.size() - k0b, 0);
    chk("mid_busy1", 32'(bus.c1_busy), 0);

    chk("never_both_done", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
